// File: rtl/automatic_washing_machine.sv
`default_nettype none
// ============================================================================
// Module      : automatic_washing_machine
// Description : Washing machine sequencer: wash pass, rinse pass, spin, done.
// Revision    : 1.0  initial release
// ============================================================================
module automatic_washing_machine (
  input  logic clk,
  input  logic reset,
  input  logic door_close,
  input  logic start,
  input  logic filled,
  input  logic detergent_added,
  input  logic cycle_timeout,
  input  logic drained,
  input  logic spin_timeout,
  output logic door_lock,
  output logic motor_on,
  output logic fill_value_on,
  output logic drain_value_on,
  output logic done,
  output logic soap_wash,
  output logic water_wash
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FILL    = 3'd1;
  localparam logic [2:0] S_ADD_DET = 3'd2;
  localparam logic [2:0] S_CYCLE   = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [2:0] S_SPIN    = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0] state_q, state_d;
  logic       soap_q, soap_d;
  logic       water_q, water_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      soap_q  <= 1'b0;
      water_q <= 1'b0;
    end else begin
      state_q <= state_d;
      soap_q  <= soap_d;
      water_q <= water_d;
    end
  end

  // The pass flags advance alongside the state so the second FILL/DRAIN know
  // whether this is the rinse pass.
  always_comb begin
    state_d = state_q;
    soap_d  = soap_q;
    water_d = water_q;
    case (state_q)
      S_IDLE: begin
        if (start && door_close) state_d = S_FILL;
      end
      S_FILL: begin
        if (filled) state_d = soap_q ? S_CYCLE : S_ADD_DET;
      end
      S_ADD_DET: begin
        if (detergent_added) begin
          state_d = S_CYCLE;
          soap_d  = 1'b1;
        end
      end
      S_CYCLE: begin
        if (cycle_timeout) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drained) begin
          if (water_q) begin
            state_d = S_SPIN;
          end else begin
            state_d = S_FILL;
            water_d = 1'b1;
          end
        end
      end
      S_SPIN: begin
        if (spin_timeout) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        soap_d  = 1'b0;
        water_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        soap_d  = 1'b0;
        water_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    door_lock      = 1'b0;
    motor_on       = 1'b0;
    fill_value_on  = 1'b0;
    drain_value_on = 1'b0;
    done           = 1'b0;
    case (state_q)
      S_FILL: begin
        door_lock     = 1'b1;
        fill_value_on = 1'b1;
      end
      S_ADD_DET: begin
        door_lock = 1'b1;
      end
      S_CYCLE: begin
        door_lock = 1'b1;
        motor_on  = 1'b1;
      end
      S_DRAIN: begin
        door_lock      = 1'b1;
        drain_value_on = 1'b1;
      end
      S_SPIN: begin
        door_lock      = 1'b1;
        motor_on       = 1'b1;
        drain_value_on = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        door_lock = 1'b0;
      end
    endcase
  end

  assign soap_wash  = soap_q;
  assign water_wash = water_q;

endmodule
`default_nettype wire

// File: tb/tb_automatic_washing_machine.sv
`default_nettype none
// ============================================================================
// Module      : tb_automatic_washing_machine
// Description : Directed self-checking bench for automatic_washing_machine.
// Revision    : 1.0  initial release
// ============================================================================
module tb_automatic_washing_machine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic door_close = 1'b0;
  logic start = 1'b0;
  logic filled = 1'b0;
  logic detergent_added = 1'b0;
  logic cycle_timeout = 1'b0;
  logic drained = 1'b0;
  logic spin_timeout = 1'b0;
  logic door_lock, motor_on, fill_value_on, drain_value_on, done, soap_wash, water_wash;

  int n_checks = 0;
  int n_fails  = 0;

  // Observed vector: {door_lock, motor_on, fill, drain, done, soap, water}
  logic [6:0] obs;
  assign obs = {door_lock, motor_on, fill_value_on, drain_value_on, done, soap_wash, water_wash};

  localparam logic [6:0] E_IDLE    = 7'b0000000;
  localparam logic [6:0] E_FILL    = 7'b1010000;
  localparam logic [6:0] E_ADD_DET = 7'b1000000;
  localparam logic [6:0] E_CYCLE   = 7'b1100010;
  localparam logic [6:0] E_DRAIN   = 7'b1001010;
  localparam logic [6:0] E_FILL_R  = 7'b1010011;
  localparam logic [6:0] E_CYCLE_R = 7'b1100011;
  localparam logic [6:0] E_DRAIN_R = 7'b1001011;
  localparam logic [6:0] E_SPIN    = 7'b1101011;
  localparam logic [6:0] E_DONE    = 7'b0000111;

  automatic_washing_machine dut (
    .clk             (clk),
    .reset           (reset),
    .door_close      (door_close),
    .start           (start),
    .filled          (filled),
    .detergent_added (detergent_added),
    .cycle_timeout   (cycle_timeout),
    .drained         (drained),
    .spin_timeout    (spin_timeout),
    .door_lock       (door_lock),
    .motor_on        (motor_on),
    .fill_value_on   (fill_value_on),
    .drain_value_on  (drain_value_on),
    .done            (done),
    .soap_wash       (soap_wash),
    .water_wash      (water_wash)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic v);
    door_close = v; start = v; filled = v; detergent_added = v;
    cycle_timeout = v; drained = v; spin_timeout = v;
  endtask

  logic [6:0] full_seq [10];

  initial begin
    full_seq[0] = E_FILL;    full_seq[1] = E_ADD_DET; full_seq[2] = E_CYCLE;
    full_seq[3] = E_DRAIN;   full_seq[4] = E_FILL_R;  full_seq[5] = E_CYCLE_R;
    full_seq[6] = E_DRAIN_R; full_seq[7] = E_SPIN;    full_seq[8] = E_DONE;
    full_seq[9] = E_IDLE;

    // Reset held for two edges
    tick(); tick();
    check("reset_state", obs, E_IDLE);

    // All inputs high from the first post-reset edge: done on edge 9, IDLE on edge 10
    reset = 1'b0;
    set_all(1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("allhigh_edge%0d", i + 1), obs, full_seq[i]);
    end
    set_all(1'b0);

    // Start without closed door must not leave IDLE
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("door_open_idle%0d", i), obs, E_IDLE);
    end

    // Staggered sensors, door and start dropped while in FILL
    door_close = 1'b1;
    tick();
    check("stag_fill", obs, E_FILL);
    door_close = 1'b0;
    start = 1'b0;
    drained = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("stag_fill_hold%0d", i), obs, E_FILL);
    end
    drained = 1'b0;
    filled = 1'b1;
    tick();
    check("stag_add_det", obs, E_ADD_DET);
    for (int i = 0; i < 9; i++) tick();
    check("stag_add_det_hold", obs, E_ADD_DET);
    detergent_added = 1'b1;
    tick();
    check("stag_cycle", obs, E_CYCLE);
    for (int i = 0; i < 9; i++) tick();
    check("stag_cycle_hold", obs, E_CYCLE);
    cycle_timeout = 1'b1;
    tick();
    check("stag_drain", obs, E_DRAIN);
    for (int i = 0; i < 9; i++) tick();
    check("stag_drain_hold", obs, E_DRAIN);
    drained = 1'b1;
    tick();
    check("stag_fill_rinse", obs, E_FILL_R);
    tick();
    check("stag_cycle_rinse", obs, E_CYCLE_R);
    tick();
    check("stag_drain_rinse", obs, E_DRAIN_R);
    tick();
    check("stag_spin", obs, E_SPIN);
    for (int i = 0; i < 9; i++) tick();
    check("stag_spin_hold", obs, E_SPIN);
    spin_timeout = 1'b1;
    tick();
    check("stag_done", obs, E_DONE);
    tick();
    check("stag_idle_after", obs, E_IDLE);
    tick();
    check("stag_idle_stays", obs, E_IDLE);
    set_all(1'b0);

    // Reset during the rinse-pass CYCLE
    set_all(1'b1);
    for (int i = 0; i < 6; i++) tick();
    check("pre_reset_cycle_rinse", obs, E_CYCLE_R);
    reset = 1'b1;
    tick();
    check("reset_mid_rinse", obs, E_IDLE);
    tick();
    check("reset_held", obs, E_IDLE);
    reset = 1'b0;
    set_all(1'b0);
    tick();
    check("idle_after_reset", obs, E_IDLE);

    // A new program after reset starts the wash pass fresh
    door_close = 1'b1;
    start = 1'b1;
    tick();
    check("restart_fill", obs, E_FILL);
    filled = 1'b1;
    tick();
    check("restart_add_det", obs, E_ADD_DET);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/automatic_washing_machine.md
AUTOMATIC_WASHING_MACHINE -- requirements
Module: automatic_washing_machine

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk, rising-edge; reset sampled only on the rising edge of clk.
REQ-002 Port list, in this order: name  direction  width  meaning.
REQ-003 clk  input  1  system clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 door_close  input  1  1 = door shut.
REQ-006 start  input  1  user start request (level).
REQ-007 filled  input  1  water-level sensor: tub full.
REQ-008 detergent_added  input  1  detergent dispensed.
REQ-009 cycle_timeout  input  1  wash/rinse agitation timer expired.
REQ-010 drained  input  1  tub empty sensor.
REQ-011 spin_timeout  input  1  spin timer expired.
REQ-012 door_lock  output  1  door latch engaged.
REQ-013 motor_on  output  1  drum motor running.
REQ-014 fill_value_on  output  1  fill valve open.
REQ-015 drain_value_on  output  1  drain valve open.
REQ-016 done  output  1  program complete.
REQ-017 soap_wash  output  1  soap (detergent) pass completed or in progress.
REQ-018 water_wash  output  1  rinse pass in progress.

Function
REQ-019 The FSM SHALL have seven states: IDLE, FILL, ADD_DET, CYCLE, DRAIN, SPIN, DONE. It SHALL advance at most one state per clk edge.
REQ-020 IDLE -> FILL when start=1 and door_close=1; otherwise stay in IDLE.
REQ-021 FILL -> ADD_DET when filled=1 and soap_wash=0; FILL -> CYCLE when filled=1 and soap_wash=1; otherwise stay in FILL.
REQ-022 ADD_DET -> CYCLE when detergent_added=1, and soap_wash is set to 1 on that same edge.
REQ-023 CYCLE -> DRAIN when cycle_timeout=1.
REQ-024 DRAIN with drained=1: water_wash=0 -> FILL and water_wash set to 1 on that edge (rinse pass); water_wash=1 -> SPIN.
REQ-025 SPIN -> DONE when spin_timeout=1.
REQ-026 DONE -> IDLE unconditionally after exactly one cycle; soap_wash and water_wash cleared on that edge.
REQ-027 Outputs SHALL be Moore outputs, decoded from the state register and flag registers only, with no combinational input-to-output path.
REQ-028 Output decode per state (any output not listed is 0):
- IDLE: all outputs 0.
- FILL: door_lock=1, fill_value_on=1.
- ADD_DET: door_lock=1.
- CYCLE: door_lock=1, motor_on=1.
- DRAIN: door_lock=1, drain_value_on=1.
- SPIN: door_lock=1, motor_on=1, drain_value_on=1.
- DONE: done=1, door_lock=0.
REQ-029 soap_wash and water_wash SHALL be registered flags driven directly to their ports.
REQ-030 In all non-IDLE states, door_close and start SHALL be ignored (door is locked); deasserting either mid-program has no effect.
REQ-031 Sensor inputs asserted in a state that does not consume them SHALL be ignored. Inputs held high permanently SHALL advance the FSM one state per cycle.
REQ-032 fill_value_on and drain_value_on SHALL never be 1 simultaneously, and fill_value_on and motor_on SHALL never be 1 simultaneously.
REQ-033 Full program latency with all sensors pre-asserted: IDLE, FILL, ADD_DET, CYCLE, DRAIN, FILL, CYCLE, DRAIN, SPIN, DONE, IDLE = 10 edges from start.

Reset
REQ-034 reset=1 at a rising clk edge SHALL force IDLE, clear soap_wash and water_wash, and drive all outputs to 0 from that edge, in any state, including mid-program.
REQ-035 reset SHALL take priority over all other inputs. After reset is released, the FSM waits in IDLE for start and door_close.

Verification
REQ-036 Hold reset=1 for 2 edges from any state -> all 7 outputs = 0, state IDLE.
REQ-037 start=1, door_close=0 for 5 cycles -> remains IDLE, door_lock=0, fill_value_on=0.
REQ-038 start=1, door_close=1, then filled, detergent_added, cycle_timeout, drained, spin_timeout each raised 10 cycles apart, held high -> the state sequence of REQ-033 occurs; soap_wash=1 from CYCLE onward; water_wash=1 from the second FILL; done=1 for exactly 1 cycle; IDLE afterward with flags=0.
REQ-039 All inputs high from the first post-reset edge -> done asserted on the 9th edge after start is sampled, and the FSM returns to IDLE on the 10th.
REQ-040 Assert reset while in CYCLE of the rinse pass -> next edge IDLE, soap_wash=0, water_wash=0, motor_on=0, door_lock=0.
REQ-041 Drop door_close to 0 while in FILL -> FILL held, door_lock=1, fill_value_on=1 until filled=1.
